// File: rtl/data_mem_pkg.sv
// Shared definitions for the CPU data-memory responder: state encoding,
// latency counter width and the byte-lane merge used by storage and responder.
package data_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int CNT_W = 4;

    // Replace the byte lanes of old_word selected by wen with those of new_word.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  wen
    );
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (wen[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/data_ram_array.sv
// DEPTH x 32 word storage: one synchronous-write / asynchronous-read port
// with byte-lane enables, plus an asynchronous read port for the debug display.
module data_ram_array
    import data_mem_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    wen,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    input  logic [AW-1:0] test_addr,
    output logic [31:0]   test_data
);

    localparam int DEPTH = 2 ** AW;

    logic [31:0] mem [DEPTH];

    // Byte-lane write on the rising edge; untouched lanes keep their value.
    // NOTE: the storage array is deliberately not reset -- contents survive resetn
    // and a reset term would prevent mapping onto RAM primitives.
    always_ff @(posedge clk) begin
        if (|wen) begin
            mem[addr] <= merge_bytes(mem[addr], wdata, wen);
        end
    end

    assign rdata     = mem[addr];
    assign test_data = mem[test_addr];

endmodule

// File: rtl/data_ram_responder.sv
// Handshaked data-memory responder: accepts one read or byte-lane write at a
// time and answers after LATENCY cycles; storage lives in data_ram_array.
// Optional feature macro: DATA_RAM_RANGE_CHECK_EN adds resp_err and rejects
// addresses with any bit set above the word index instead of wrapping them.
module data_ram_responder
    import data_mem_pkg::*;
#(
    parameter int AW      = 5,
    parameter int LATENCY = 2
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [31:0]   req_addr,
    input  logic [3:0]    req_wen,
    input  logic [31:0]   req_wdata,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [31:0]   resp_rdata,
`ifdef DATA_RAM_RANGE_CHECK_EN
    output logic          resp_err,
`endif
    input  logic [AW-1:0] test_addr,
    output logic [31:0]   test_data
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [AW-1:0]    lat_idx;
    logic             lat_oor;

    logic             accept;
    logic             req_oor;
    logic [AW-1:0]    req_idx;
    logic [AW-1:0]    mem_addr;
    logic [3:0]       mem_wen;
    logic [31:0]      rd_word;

    assign req_idx = req_addr[AW+1:2];
    assign accept  = req_valid & req_ready & (state == IDLE);

`ifdef DATA_RAM_RANGE_CHECK_EN
    assign req_oor = |req_addr[31:AW+2];
    logic unused_byte_offset;
    assign unused_byte_offset = ^req_addr[1:0];
`else
    assign req_oor = 1'b0;
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};
`endif

    // The single memory port follows the live request while idle (so the write
    // commits on the accept edge) and the latched index while a request is open.
    assign mem_addr = (state == IDLE) ? req_idx : lat_idx;
    assign mem_wen  = (accept && !req_oor) ? req_wen : 4'b0000;

    data_ram_array #(.AW(AW)) u_array (
        .clk       (clk),
        .addr      (mem_addr),
        .wen       (mem_wen),
        .wdata     (req_wdata),
        .rdata     (rd_word),
        .test_addr (test_addr),
        .test_data (test_data)
    );

    // Request/response FSM with latency counter and registered handshake outputs.
    // NOTE: every state element here uses <= so all updates see pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            cnt        <= '0;
            lat_idx    <= '0;
            lat_oor    <= 1'b0;
`ifdef DATA_RAM_RANGE_CHECK_EN
            resp_err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_idx   <= req_idx;
                        lat_oor   <= req_oor;
                        req_ready <= 1'b0;
                        if (LATENCY == 1) begin
                            // Memory still holds the old word here, so merge in the write.
                            resp_rdata <= req_oor ? '0 : merge_bytes(rd_word, req_wdata, req_wen);
                            resp_valid <= 1'b1;
`ifdef DATA_RAM_RANGE_CHECK_EN
                            resp_err   <= req_oor;
`endif
                            cnt        <= '0;
                            state      <= RESP;
                        end else begin
                            cnt   <= CNT_INIT;
                            state <= WAIT;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_LAST) begin
                        resp_rdata <= lat_oor ? '0 : rd_word;
                        resp_valid <= 1'b1;
`ifdef DATA_RAM_RANGE_CHECK_EN
                        resp_err   <= lat_oor;
`endif
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_ram_responder.sv
// Self-checking bench for data_ram_responder: directed scenarios plus random
// transactions compared against a word-array reference model. A second
// instance with LATENCY=1 covers back-to-back accepts.
module tb_data_ram_responder;

`ifdef DATA_RAM_RANGE_CHECK_EN
    localparam bit RANGE_EN = 1'b1;
`else
    localparam bit RANGE_EN = 1'b0;
`endif
    localparam int AW  = 5;
    localparam int LAT = 2;

    logic          clk;
    logic          resetn;
    logic          req_valid, req_ready, resp_valid, resp_ready;
    logic [31:0]   req_addr, req_wdata, resp_rdata, test_data;
    logic [3:0]    req_wen;
    logic [AW-1:0] test_addr;
    logic          resp_err;

    logic          b_req_valid, b_req_ready, b_resp_valid, b_resp_ready;
    logic [31:0]   b_req_addr, b_req_wdata, b_resp_rdata, b_test_data;
    logic [3:0]    b_req_wen;
    logic [AW-1:0] b_test_addr;
    logic          b_resp_err;

    logic [31:0] model   [32];
    logic [31:0] b_model [32];

    int checks = 0;
    int errors = 0;

    data_ram_responder #(.AW(AW), .LATENCY(LAT)) u_dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_wen    (req_wen),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
`ifdef DATA_RAM_RANGE_CHECK_EN
        .resp_err   (resp_err),
`endif
        .test_addr  (test_addr),
        .test_data  (test_data)
    );

    data_ram_responder #(.AW(AW), .LATENCY(1)) u_dut1 (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (b_req_valid),
        .req_ready  (b_req_ready),
        .req_addr   (b_req_addr),
        .req_wen    (b_req_wen),
        .req_wdata  (b_req_wdata),
        .resp_valid (b_resp_valid),
        .resp_ready (b_resp_ready),
        .resp_rdata (b_resp_rdata),
`ifdef DATA_RAM_RANGE_CHECK_EN
        .resp_err   (b_resp_err),
`endif
        .test_addr  (b_test_addr),
        .test_data  (b_test_data)
    );

`ifndef DATA_RAM_RANGE_CHECK_EN
    assign resp_err   = 1'b0;
    assign b_resp_err = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Byte-lane merge expressed as masking arithmetic.
    function automatic logic [31:0] model_merge(input logic [31:0] o, input logic [31:0] n,
                                                input logic [3:0] w);
        logic [31:0] r;
        logic [31:0] m;
        r = o;
        for (int b = 0; b < 4; b++) begin
            m = 32'hFF << (8 * b);
            if (w[b]) r = (r & ~m) | (n & m);
        end
        return r;
    endfunction

    // One full transaction on the LATENCY=2 instance. Starts and ends at a negedge.
    // Garbage requests are driven while busy; they must be ignored.
    task automatic txn(input string tag, input logic [31:0] addr, input logic [3:0] wen,
                       input logic [31:0] wdata, input int bp, output logic [31:0] got);
        logic [31:0] exp;
        logic [31:0] held;
        logic        oor;
        int          idx;
        int          n;
        idx = int'(addr[6:2]);
        oor = RANGE_EN && (addr[31:7] != 25'd0);
        if (!oor) model[idx] = model_merge(model[idx], wdata, wen);
        exp = oor ? 32'd0 : model[idx];

        req_valid  = 1'b1;
        req_addr   = addr;
        req_wen    = wen;
        req_wdata  = wdata;
        resp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check({tag, "_accept_timeout"}, 32'd0, 32'd1);
            req_valid = 1'b0;
            got = '0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_addr  = $urandom;
        req_wen   = 4'hF;
        req_wdata = $urandom;
        n = 1;
        while (!resp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, n, LAT);
        check({tag, "_rdata"}, resp_rdata, exp);
        if (RANGE_EN) check({tag, "_err"}, {31'd0, resp_err}, {31'd0, oor});
        held = resp_rdata;
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check({tag, "_bp_valid"}, {31'd0, resp_valid}, 32'd1);
            check({tag, "_bp_rdata"}, resp_rdata, held);
            check({tag, "_bp_ready"}, {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check({tag, "_done_valid"}, {31'd0, resp_valid}, 32'd0);
        check({tag, "_done_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b0;
        resp_ready = 1'b0;
        test_addr  = AW'(idx);
        #1;
        check({tag, "_test_data"}, test_data, model[idx]);
        got = held;
    endtask

    logic [31:0] got;
    logic [31:0] r_addr;
    logic [31:0] op_addr [6];
    logic [3:0]  op_wen  [6];
    logic [31:0] op_wd   [6];
    logic [31:0] op_exp  [6];

    initial begin
        resetn = 1'b1;
        req_valid = 1'b0; req_addr = '0; req_wen = '0; req_wdata = '0;
        resp_ready = 1'b0; test_addr = '0;
        b_req_valid = 1'b0; b_req_addr = '0; b_req_wen = '0; b_req_wdata = '0;
        b_resp_ready = 1'b0; b_test_addr = '0;
        #2 resetn = 1'b0;
        #1;
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        if (RANGE_EN) check("rst_resp_err", {31'd0, resp_err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        #1 check("rel_req_ready_low", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("rel_req_ready_high", {31'd0, req_ready}, 32'd1);

        // Fill memory so the model is fully known.
        for (int i = 0; i < 32; i++) txn("init", 32'(i * 4), 4'hF, $urandom, 0, got);

        // Reset in the middle of WAIT: write commits, response is dropped.
        req_valid = 1'b1; req_addr = 32'h0000000C; req_wen = 4'hF; req_wdata = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        model[3] = 32'hCAFEF00D;
        check("midwait_valid", {31'd0, resp_valid}, 32'd0);
        resetn = 1'b0;
        #1;
        check("midrst_valid", {31'd0, resp_valid}, 32'd0);
        check("midrst_ready", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        #1 check("midrel_ready_low", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        check("midrel_ready_high", {31'd0, req_ready}, 32'd1);
        check("midrel_no_resp", {31'd0, resp_valid}, 32'd0);
        test_addr = 5'd3;
        #1 check("midrel_test_data", test_data, 32'hCAFEF00D);
        @(negedge clk);

        // Full write then read.
        txn("wr_full", 32'h0000000C, 4'hF, 32'hDEADBEEF, 0, got);
        check("wr_full_const", got, 32'hDEADBEEF);
        txn("rd_full", 32'h0000000C, 4'h0, 32'h0, 0, got);
        check("rd_full_const", got, 32'hDEADBEEF);
        test_addr = 5'd3;
        #1 check("wr_full_test3", test_data, 32'hDEADBEEF);

        // Backpressure for 5 cycles.
        txn("bp", 32'h00000010, 4'h0, 32'h0, 5, got);

        // Partial writes.
        txn("pw_init", 32'h00000004, 4'hF, 32'h11223344, 0, got);
        txn("pw_lane1", 32'h00000004, 4'b0010, 32'h0000AA00, 1, got);
        check("pw_lane1_const", got, 32'h1122AA44);
        txn("pw_lane3", 32'h00000004, 4'b1000, 32'h55000000, 0, got);
        check("pw_lane3_const", got, 32'h5522AA44);

        // Wrap / range check.
        txn("wrap_pre", 32'h00000000, 4'hF, 32'hA5A5A5A5, 0, got);
        txn("wrap_wr", 32'h00000080, 4'hF, 32'h12345678, 0, got);
        txn("wrap_rd", 32'h00000000, 4'h0, 32'h0, 0, got);
        if (RANGE_EN) check("wrap_rd_const", got, 32'hA5A5A5A5);
        else          check("wrap_rd_const", got, 32'h12345678);

        // Random traffic against the model.
        for (int t = 0; t < 60; t++) begin
            r_addr = {$urandom_range(0, 31), 2'(0)} | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) r_addr = r_addr | ($urandom << 7);
            txn("rand", r_addr, 4'($urandom), $urandom, $urandom_range(0, 3), got);
        end

        // LATENCY=1 instance: back-to-back with req_valid held high.
        for (int k = 0; k < 6; k++) begin
            op_addr[k] = 32'((k % 3) * 4);
            op_wen[k]  = (k < 3) ? 4'hF : 4'h0;
            op_wd[k]   = $urandom;
        end
        b_resp_ready = 1'b1;
        begin
            int k;
            int prev;
            bit pend;
            k = 0; prev = -1; pend = 1'b0;
            b_req_valid = 1'b1;
            for (int c = 0; c < 80 && (k < 6 || pend); c++) begin
                @(negedge clk);
                if (pend) begin
                    check("b2b_resp_valid", {31'd0, b_resp_valid}, 32'd1);
                    check("b2b_rdata", b_resp_rdata, op_exp[k-1]);
                    check("b2b_ready_low", {31'd0, b_req_ready}, 32'd0);
                    pend = 1'b0;
                end
                if (k < 6) begin
                    b_req_addr = op_addr[k]; b_req_wen = op_wen[k]; b_req_wdata = op_wd[k];
                    if (b_req_ready) begin
                        if (prev >= 0) check("b2b_spacing", c - prev, 2);
                        prev = c;
                        b_model[k % 3] = model_merge(b_model[k % 3], op_wd[k], op_wen[k]);
                        op_exp[k] = b_model[k % 3];
                        pend = 1'b1;
                        k++;
                    end
                end else begin
                    b_req_valid = 1'b0;
                end
            end
            b_req_valid = 1'b0;
            check("b2b_count", k, 6);
            check("b2b_read2", op_exp[5], op_wd[2]);
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
